// File: rtl/ft245_arb_pkg.sv
// Shared state encoding, counter widths and default timing for the FT245 bus arbiter.
package ft245_arb_pkg;

  typedef enum logic [3:0] {
    IDLE,
    OWN,
    WAIT_RXF,
    RD_LOW,
    RD_END,
    WAIT_TXE,
    WR_HIGH,
    WR_LOW,
    RELEASE
  } arb_state_t;

  localparam int NRD_CYCLES_DEFAULT = 3;
  localparam int WR_CYCLES_DEFAULT  = 2;
  localparam int HOLD_MAX_DEFAULT   = 64;

  localparam int OP_CNT_W = 7;
  localparam int PHASE_W  = 8;

  function automatic logic [1:0] one_hot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ft245_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the client not granted last.
module ft245_rr_pick
  import ft245_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       pick
);

  always_comb begin
    valid = |req;
    pick  = 1'b0;
    if (req == 2'b11) begin
      pick = ~last;
    end else if (req[1]) begin
      pick = 1'b1;
    end
  end

endmodule

// File: rtl/ft245_bus_arbiter.sv
// Shares one FT245 FIFO port between two clients; the grant holder issues byte reads/writes
// and yields after HOLD_MAX completed operations when the other client is waiting.
module ft245_bus_arbiter
  import ft245_arb_pkg::*;
#(
  parameter int NRD_CYCLES = NRD_CYCLES_DEFAULT,
  parameter int WR_CYCLES  = WR_CYCLES_DEFAULT,
  parameter int HOLD_MAX   = HOLD_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nrxf,
  input  logic        ntxe,
  output logic        nrd,
  output logic        wr,
  inout  wire  [7:0]  d,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  input  logic [1:0]  op_valid,
  input  logic [1:0]  op_wr,
  input  logic [15:0] wdata,
  output logic [1:0]  done,
  output logic [7:0]  rdata
);

  arb_state_t          state;
  logic                owner;
  logic                last;
  logic [OP_CNT_W-1:0] op_cnt;
  logic [PHASE_W-1:0]  phase;
  logic [7:0]          wbyte;

  logic                pick_valid;
  logic                pick;
  logic [1:0]          owner_bit;
  logic                at_hold;
  logic                other_req;
  logic [OP_CNT_W-1:0] op_cnt_next;

  ft245_rr_pick u_pick (
    .req   (req),
    .last  (last),
    .valid (pick_valid),
    .pick  (pick)
  );

  assign owner_bit   = one_hot(owner);
  assign at_hold     = (op_cnt == OP_CNT_W'(HOLD_MAX));
  assign other_req   = owner ? req[0] : req[1];
  assign op_cnt_next = at_hold ? op_cnt : op_cnt + 1'b1;

  // The bus is only driven while a write is on the wire; the latched byte isolates it from wdata.
  assign d = (state == WR_HIGH || state == WR_LOW) ? wbyte : 8'bz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= 1'b0;
      last   <= 1'b1;
      op_cnt <= '0;
      phase  <= '0;
      wbyte  <= '0;
      nrd    <= 1'b1;
      wr     <= 1'b0;
      gnt    <= 2'b00;
      done   <= 2'b00;
      rdata  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner <= pick;
            last  <= pick;
            gnt   <= one_hot(pick);
            state <= OWN;
          end
        end
        OWN: begin
          if (!req[owner] || (at_hold && other_req)) begin
            gnt   <= 2'b00;
            state <= RELEASE;
          end else begin
            // Nobody else is waiting, so the owner simply starts a fresh quota.
            if (at_hold) begin
              op_cnt <= '0;
            end
            if (op_valid[owner]) begin
              state <= op_wr[owner] ? WAIT_TXE : WAIT_RXF;
            end
          end
        end
        WAIT_RXF: begin
          if (!nrxf) begin
            nrd   <= 1'b0;
            phase <= '0;
            state <= RD_LOW;
          end
        end
        RD_LOW: begin
          if (phase == PHASE_W'(NRD_CYCLES - 1)) begin
            rdata <= d;
            nrd   <= 1'b1;
            done  <= owner_bit;
            state <= RD_END;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        RD_END: begin
          done   <= 2'b00;
          op_cnt <= op_cnt_next;
          state  <= OWN;
        end
        WAIT_TXE: begin
          if (!ntxe) begin
            wbyte <= owner ? wdata[15:8] : wdata[7:0];
            wr    <= 1'b1;
            phase <= '0;
            state <= WR_HIGH;
          end
        end
        WR_HIGH: begin
          if (phase == PHASE_W'(WR_CYCLES - 1)) begin
            wr    <= 1'b0;
            done  <= owner_bit;
            state <= WR_LOW;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        WR_LOW: begin
          done   <= 2'b00;
          op_cnt <= op_cnt_next;
          state  <= OWN;
        end
        RELEASE: begin
          op_cnt <= '0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
